// File: rtl/txn_retry_pkg.sv
// Shared types and default parameters for the transaction retry controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package txn_retry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_MAX_RETRY   = 2;
    localparam int DEF_BACKOFF_CYC = 3;
    localparam int DEF_CNT_W       = 8;

    // Width needed to hold values 0..n, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/txn_backoff_timer.sv
// Load/count-down timer; done is high while the count sits at zero.
// Latency: load takes effect next cycle; one decrement per enabled cycle.
// Backpressure: none (free-running while enabled).
module txn_backoff_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load wins over counting; counting stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/txn_retry_ctrl.sv
// Issues one transaction at a time, re-issuing after a backoff on watchdog timeout (optional stats: TXN_RETRY_STATS_EN).
// Latency: issue pulse 1 cycle after accept; re-issue BACKOFF_CYC+1 cycles after timeout; done 1 cycle after resp/final timeout.
// Backpressure: req_ready only in IDLE and not on the done cycle; one transaction in flight.
module txn_retry_ctrl
    import txn_retry_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int BACKOFF_CYC = DEF_BACKOFF_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [DATA_W-1:0]                 req_data,
    output logic                              issue_valid,
    output logic [DATA_W-1:0]                 issue_data,
    input  logic                              resp_valid,
    output logic                              start_transaction,
    output logic                              complete_transaction,
    input  logic                              req_timeout,
    output logic                              done_valid,
    output logic                              done_err,
    output logic [cnt_width(MAX_RETRY)-1:0]   retry_cnt,
    output logic [CNT_W-1:0]                  err_count
);

    localparam int RC_W = cnt_width(MAX_RETRY);
    localparam int BO_W = cnt_width(BACKOFF_CYC);
    localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(MAX_RETRY);
    // BACKOFF lasts BACKOFF_CYC cycles: loaded value counts down to zero inclusive
    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF_CYC - 1);

    state_t state;
    state_t state_nx;

    logic accept;
    logic at_limit;
    logic resp_hit;
    logic tmo_hit;
    logic bo_load;
    logic bo_done;

    logic issue_d;
    logic cmpl_d;
    logic done_d;
    logic err_d;

    // done_valid gates req_ready so the next accept lands the cycle after completion
    assign req_ready = (state == IDLE) && !done_valid;
    assign accept    = req_valid && req_ready;
    assign at_limit  = (retry_cnt == RETRY_LIM);
    // A response in the same cycle as a timeout takes priority
    assign resp_hit  = (state == WAIT) && resp_valid;
    assign tmo_hit   = (state == WAIT) && !resp_valid && req_timeout;
    assign bo_load   = tmo_hit && !at_limit;

    txn_backoff_timer #(
        .W(BO_W)
    ) u_backoff (
        .clk      (clk),
        .rst      (rst),
        .load     (bo_load),
        .load_val (BO_LOAD),
        .en       (state == BACKOFF),
        .done     (bo_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (resp_valid) begin
                    state_nx = IDLE;
                end else if (req_timeout) begin
                    state_nx = at_limit ? IDLE : BACKOFF;
                end
            end
            BACKOFF: if (bo_done) state_nx = ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: next-cycle values of the registered pulses
    always_comb begin
        issue_d = (state_nx == ISSUE);
        cmpl_d  = resp_hit;
        err_d   = tmo_hit && at_limit;
        done_d  = resp_hit || err_d;
    end

    // Registered outputs, payload capture and retry bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid          <= 1'b0;
            start_transaction    <= 1'b0;
            complete_transaction <= 1'b0;
            done_valid           <= 1'b0;
            done_err             <= 1'b0;
            issue_data           <= '0;
            retry_cnt            <= '0;
        end else begin
            issue_valid          <= issue_d;
            start_transaction    <= issue_d;
            complete_transaction <= cmpl_d;
            done_valid           <= done_d;
            done_err             <= err_d;
            if (accept) begin
                issue_data <= req_data;
                retry_cnt  <= '0;
            end else if (bo_load) begin
                retry_cnt  <= retry_cnt + RC_W'(1);
            end
        end
    end

`ifdef TXN_RETRY_STATS_EN
    // Count failed transactions, holding at all-ones once saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_d && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_txn_retry_ctrl.sv
module tb_txn_retry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       issue_valid;
    logic [7:0] issue_data;
    logic       resp_valid;
    logic       start_transaction;
    logic       complete_transaction;
    logic       req_timeout;
    logic       done_valid;
    logic       done_err;
    logic [1:0] retry_cnt;
    logic [7:0] err_count;

    int nerr = 0;
    int nchk = 0;

    // per-scenario observation counters
    int cyc = 0;
    int n_start;
    int n_cmpl;
    int n_done;
    int n_split;
    int done_cyc;
    int start_cyc[$];

`ifdef TXN_RETRY_STATS_EN
    localparam logic [7:0] ERR_AFTER_FAIL = 8'd1;
`else
    localparam logic [7:0] ERR_AFTER_FAIL = 8'd0;
`endif

    txn_retry_ctrl #(
        .DATA_W(8), .MAX_RETRY(2), .BACKOFF_CYC(3), .CNT_W(8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_data             (req_data),
        .issue_valid          (issue_valid),
        .issue_data           (issue_data),
        .resp_valid           (resp_valid),
        .start_transaction    (start_transaction),
        .complete_transaction (complete_transaction),
        .req_timeout          (req_timeout),
        .done_valid           (done_valid),
        .done_err             (done_err),
        .retry_cnt            (retry_cnt),
        .err_count            (err_count)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and log the pulses of that cycle
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (start_transaction) begin
            n_start++;
            start_cyc.push_back(cyc);
        end
        if (start_transaction !== issue_valid) n_split++;
        if (complete_transaction) n_cmpl++;
        if (done_valid) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_stats();
        n_start = 0; n_cmpl = 0; n_done = 0; n_split = 0; done_cyc = -1;
        start_cyc.delete();
    endtask

    // Present a request on an idle DUT; returns on the issue cycle
    task automatic do_req(input logic [7:0] d);
        req_valid = 1'b1;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_starts(input int want);
        for (int k = 0; k < 12 && n_start < want; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; resp_valid = 1'b0; req_timeout = 1'b0;
        clear_stats();
        tick(); tick();
        if ({issue_valid, start_transaction, complete_transaction, done_valid, done_err} !== 5'b0) begin
            nerr++; $display("FAIL reset_pulses: got %b expected 00000",
                {issue_valid, start_transaction, complete_transaction, done_valid, done_err});
        end
        nchk++;
        if (issue_data !== 8'h00) begin nerr++; $display("FAIL reset_issue_data: got %h expected 00", issue_data); end
        nchk++;
        if (retry_cnt !== 2'd0) begin nerr++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
        nchk++;
        if (err_count !== 8'd0) begin nerr++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        nchk++;
        if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        nchk++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_stats();
        do_req(8'hA5);
        if (issue_data !== 8'hA5) begin nerr++; $display("FAIL single_issue_data: got %h expected a5", issue_data); end
        nchk++;
        if (req_ready !== 1'b0) begin nerr++; $display("FAIL single_busy_ready: got %b expected 0", req_ready); end
        nchk++;
        repeat (2) tick();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        if ({done_valid, done_err, complete_transaction} !== 3'b101) begin
            nerr++; $display("FAIL single_done: got %b expected 101", {done_valid, done_err, complete_transaction});
        end
        nchk++;
        if (req_ready !== 1'b0) begin nerr++; $display("FAIL single_ready_on_done: got %b expected 0", req_ready); end
        nchk++;
        tick();
        if (req_ready !== 1'b1) begin nerr++; $display("FAIL single_ready_after: got %b expected 1", req_ready); end
        nchk++;
        if ({n_start, n_cmpl, n_done, n_split} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            nerr++; $display("FAIL single_counts: got start=%0d cmpl=%0d done=%0d split=%0d expected 1 1 1 0",
                n_start, n_cmpl, n_done, n_split);
        end
        nchk++;
        if (retry_cnt !== 2'd0) begin nerr++; $display("FAIL single_retry_cnt: got %0d expected 0", retry_cnt); end
        nchk++;
    endtask

    task automatic test_one_retry();
        int t;
        clear_stats();
        do_req(8'h3C);
        tick();
        req_timeout = 1'b1;
        t = cyc;
        tick();
        req_timeout = 1'b0;
        wait_starts(2);
        if (n_start !== 2) begin
            nerr++; $display("FAIL retry_second_start: got %0d starts expected 2", n_start);
        end else if (start_cyc[1] - t !== 4) begin
            nerr++; $display("FAIL retry_reissue_gap: got %0d cycles expected 4", start_cyc[1] - t);
        end
        nchk++;
        if (issue_data !== 8'h3C) begin nerr++; $display("FAIL retry_issue_data: got %h expected 3c", issue_data); end
        nchk++;
        tick();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        if ({done_valid, done_err} !== 2'b10) begin
            nerr++; $display("FAIL retry_done: got %b expected 10", {done_valid, done_err});
        end
        nchk++;
        if (retry_cnt !== 2'd1) begin nerr++; $display("FAIL retry_cnt_one: got %0d expected 1", retry_cnt); end
        nchk++;
        tick();
        if ({n_start, n_cmpl, n_done} !== {32'd2, 32'd1, 32'd1}) begin
            nerr++; $display("FAIL retry_counts: got start=%0d cmpl=%0d done=%0d expected 2 1 1", n_start, n_cmpl, n_done);
        end
        nchk++;
    endtask

    task automatic test_exhaust();
        clear_stats();
        if (err_count !== 8'd0) begin nerr++; $display("FAIL exhaust_err_before: got %0d expected 0", err_count); end
        nchk++;
        do_req(8'h5A);
        for (int a = 0; a < 3; a++) begin
            tick();
            req_timeout = 1'b1;
            tick();
            req_timeout = 1'b0;
            if (a < 2) wait_starts(a + 2);
        end
        if ({done_valid, done_err, complete_transaction} !== 3'b110) begin
            nerr++; $display("FAIL exhaust_done: got %b expected 110", {done_valid, done_err, complete_transaction});
        end
        nchk++;
        if (retry_cnt !== 2'd2) begin nerr++; $display("FAIL exhaust_retry_cnt: got %0d expected 2", retry_cnt); end
        nchk++;
        tick();
        if ({n_start, n_cmpl, n_done} !== {32'd3, 32'd0, 32'd1}) begin
            nerr++; $display("FAIL exhaust_counts: got start=%0d cmpl=%0d done=%0d expected 3 0 1", n_start, n_cmpl, n_done);
        end
        nchk++;
        if (n_start == 3 && (start_cyc[1] - start_cyc[0] !== 5 || start_cyc[2] - start_cyc[1] !== 5)) begin
            nerr++; $display("FAIL exhaust_spacing: got %0d,%0d expected 5,5",
                start_cyc[1] - start_cyc[0], start_cyc[2] - start_cyc[1]);
        end
        nchk++;
        if (err_count !== ERR_AFTER_FAIL) begin
            nerr++; $display("FAIL exhaust_err_count: got %0d expected %0d", err_count, ERR_AFTER_FAIL);
        end
        nchk++;
    endtask

    task automatic test_simultaneous();
        clear_stats();
        do_req(8'h11);
        tick();
        resp_valid = 1'b1;
        req_timeout = 1'b1;
        tick();
        resp_valid = 1'b0;
        req_timeout = 1'b0;
        if ({done_valid, done_err, complete_transaction} !== 3'b101) begin
            nerr++; $display("FAIL simul_done: got %b expected 101", {done_valid, done_err, complete_transaction});
        end
        nchk++;
        if (retry_cnt !== 2'd0) begin nerr++; $display("FAIL simul_retry_cnt: got %0d expected 0", retry_cnt); end
        nchk++;
        repeat (6) tick();
        if ({n_start, n_done} !== {32'd1, 32'd1}) begin
            nerr++; $display("FAIL simul_no_reissue: got start=%0d done=%0d expected 1 1", n_start, n_done);
        end
        nchk++;
    endtask

    task automatic test_back_to_back();
        clear_stats();
        req_valid = 1'b1;
        req_data  = 8'h77;
        tick();
        req_data  = 8'h88;
        tick();
        if (req_ready !== 1'b0 || issue_data !== 8'h77) begin
            nerr++; $display("FAIL b2b_busy: got ready=%b data=%h expected 0 77", req_ready, issue_data);
        end
        nchk++;
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        if (done_valid !== 1'b1 || req_ready !== 1'b0) begin
            nerr++; $display("FAIL b2b_done_cycle: got done=%b ready=%b expected 1 0", done_valid, req_ready);
        end
        nchk++;
        tick();
        if (req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready_after: got %b expected 1", req_ready); end
        nchk++;
        tick();
        req_valid = 1'b0;
        if (start_transaction !== 1'b1 || issue_data !== 8'h88) begin
            nerr++; $display("FAIL b2b_second_issue: got start=%b data=%h expected 1 88", start_transaction, issue_data);
        end
        nchk++;
        if (n_start !== 2 || cyc - done_cyc !== 2) begin
            nerr++; $display("FAIL b2b_accept_timing: got starts=%0d gap=%0d expected 2 2", n_start, cyc - done_cyc);
        end
        nchk++;
        tick();
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        clear_stats();
        do_req(8'h42);
        tick();
        rst = 1'b1;
        #1;
        if ({issue_data, retry_cnt, err_count} !== 18'd0 || req_ready !== 1'b1) begin
            nerr++; $display("FAIL rstwait_clear: got data=%h rc=%0d err=%0d ready=%b expected 0 0 0 1",
                issue_data, retry_cnt, err_count, req_ready);
        end
        nchk++;
        tick();
        rst = 1'b0;
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        repeat (3) tick();
        if ({n_done, n_cmpl} !== {32'd0, 32'd0} || req_ready !== 1'b1) begin
            nerr++; $display("FAIL rstwait_late_resp: got done=%0d cmpl=%0d ready=%b expected 0 0 1", n_done, n_cmpl, req_ready);
        end
        nchk++;

        clear_stats();
        do_req(8'h43);
        tick();
        req_timeout = 1'b1;
        tick();
        req_timeout = 1'b0;
        if (retry_cnt !== 2'd1) begin nerr++; $display("FAIL rstbo_pre: got %0d expected 1", retry_cnt); end
        nchk++;
        rst = 1'b1;
        #1;
        if ({issue_valid, start_transaction, done_valid, done_err, retry_cnt, issue_data} !== 14'd0) begin
            nerr++; $display("FAIL rstbo_clear: got valid=%b start=%b done=%b err=%b rc=%0d data=%h expected all 0",
                issue_valid, start_transaction, done_valid, done_err, retry_cnt, issue_data);
        end
        nchk++;
        tick();
        rst = 1'b0;
        req_timeout = 1'b1;
        tick();
        req_timeout = 1'b0;
        repeat (6) tick();
        if ({n_start, n_done} !== {32'd1, 32'd0} || retry_cnt !== 2'd0 || req_ready !== 1'b1) begin
            nerr++; $display("FAIL rstbo_quiet: got start=%0d done=%0d rc=%0d ready=%b expected 1 0 0 1",
                n_start, n_done, retry_cnt, req_ready);
        end
        nchk++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_one_retry();
        test_exhaust();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
